// File: rtl/alu_op_sequencer.sv
// Command front-end for the 16-bit ALU: registers a command onto the ALU inputs,
// waits SETTLE cycles, captures Result/Cout and hands them back over valid/ready.
module alu_op_sequencer #(
  parameter int WIDTH  = 16,
  parameter int CTRL_W = 3,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic              cmd_cin,
  input  logic [CTRL_W-1:0] cmd_ctrl,
  input  logic              cmd_chain,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_cin,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_cout,
  output logic              busy,
  output logic [15:0]       op_count
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $fatal(1, "alu_op_sequencer: SETTLE=%0d is outside 1..15", SETTLE);
    end
  endgenerate

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  logic                alu_cin_q, alu_cin_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    rsp_result_q, rsp_result_d;
  logic                rsp_cout_q, rsp_cout_d;
  logic [15:0]         op_count_q, op_count_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    alu_ctrl_d   = alu_ctrl_q;
    acc_d        = acc_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    op_count_d   = op_count_q;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          alu_a_d    = cmd_chain ? acc_q : cmd_a;
          alu_b_d    = cmd_b;
          alu_cin_d  = cmd_cin;
          alu_ctrl_d = cmd_ctrl;
          cnt_d      = SETTLE_M1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // Counter reaching zero marks the edge on which the ALU output has settled.
        if (cnt_q == 4'd0) begin
          rsp_result_d = alu_result;
          rsp_cout_d   = alu_cout;
          acc_d        = alu_result;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      alu_ctrl_q   <= '0;
      acc_q        <= '0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      op_count_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      alu_ctrl_q   <= alu_ctrl_d;
      acc_q        <= acc_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign op_count   = op_count_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: instance 0 uses SETTLE=1 with a combinational ALU,
// instance 1 uses SETTLE=3 with an ALU whose output lags its inputs by 2 cycles.
module tb_alu_op_sequencer;
  localparam int W  = 16;
  localparam int CW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid [2];
  logic          cmd_ready [2];
  logic [W-1:0]  cmd_a     [2];
  logic [W-1:0]  cmd_b     [2];
  logic          cmd_cin   [2];
  logic [CW-1:0] cmd_ctrl  [2];
  logic          cmd_chain [2];
  logic [W-1:0]  alu_a     [2];
  logic [W-1:0]  alu_b     [2];
  logic          alu_cin   [2];
  logic [CW-1:0] alu_ctrl  [2];
  logic [W-1:0]  alu_result[2];
  logic          alu_cout  [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [W-1:0]  rsp_result[2];
  logic          rsp_cout  [2];
  logic          busy      [2];
  logic [15:0]   op_count  [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      alu_op_sequencer #(.WIDTH(W), .CTRL_W(CW), .SETTLE((gi == 0) ? 1 : 3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[gi]), .cmd_ready(cmd_ready[gi]),
        .cmd_a(cmd_a[gi]), .cmd_b(cmd_b[gi]), .cmd_cin(cmd_cin[gi]),
        .cmd_ctrl(cmd_ctrl[gi]), .cmd_chain(cmd_chain[gi]),
        .alu_a(alu_a[gi]), .alu_b(alu_b[gi]), .alu_cin(alu_cin[gi]), .alu_ctrl(alu_ctrl[gi]),
        .alu_result(alu_result[gi]), .alu_cout(alu_cout[gi]),
        .rsp_valid(rsp_valid[gi]), .rsp_ready(rsp_ready[gi]),
        .rsp_result(rsp_result[gi]), .rsp_cout(rsp_cout[gi]),
        .busy(busy[gi]), .op_count(op_count[gi])
      );
    end
  endgenerate

  function automatic logic [16:0] alu_fn(logic [15:0] a, logic [15:0] b, logic cin, logic [2:0] ctrl);
    case (ctrl)
      3'b000:  return {1'b0, a} + {1'b0, b} + 17'(cin);
      3'b001:  return {1'b0, a} + {1'b0, ~b} + 17'd1;
      3'b111:  return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  function automatic int settle_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [2:0] pick_ctrl();
    case ($urandom_range(0, 3))
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b111;
      default: return 3'($urandom);
    endcase
  endfunction

  // ALU models: instant for instance 0, two-cycle lag for instance 1
  logic [16:0] pipe1 = '0;
  logic [16:0] pipe2 = '0;
  assign {alu_cout[0], alu_result[0]} = alu_fn(alu_a[0], alu_b[0], alu_cin[0], alu_ctrl[0]);
  always @(posedge clk) begin
    pipe1 <= alu_fn(alu_a[1], alu_b[1], alu_cin[1], alu_ctrl[1]);
    pipe2 <= pipe1;
  end
  assign {alu_cout[1], alu_result[1]} = pipe2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, i, act, exp, cyc);
    end
  endtask

  // Transaction-level reference: phase 0 waiting, 1 in flight (age in cycles), 2 holding a response
  int          m_phase [2] = '{0, 0};
  int          m_age   [2] = '{0, 0};
  logic [15:0] m_a     [2] = '{16'd0, 16'd0};
  logic [15:0] m_b     [2] = '{16'd0, 16'd0};
  logic        m_cin   [2] = '{1'b0, 1'b0};
  logic [2:0]  m_ctrl  [2] = '{3'd0, 3'd0};
  logic [15:0] m_acc   [2] = '{16'd0, 16'd0};
  logic [15:0] m_res   [2] = '{16'd0, 16'd0};
  logic        m_cout  [2] = '{1'b0, 1'b0};
  logic [16:0] m_pend  [2] = '{17'd0, 17'd0};
  logic [15:0] m_cnt   [2] = '{16'd0, 16'd0};

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] = 0; m_age[i] = 0; m_a[i] = '0; m_b[i] = '0; m_cin[i] = 1'b0;
        m_ctrl[i] = '0; m_acc[i] = '0; m_res[i] = '0; m_cout[i] = 1'b0; m_cnt[i] = '0;
      end else if (m_phase[i] == 0) begin
        if (cmd_valid[i]) begin
          m_a[i]    = cmd_chain[i] ? m_acc[i] : cmd_a[i];
          m_b[i]    = cmd_b[i];
          m_cin[i]  = cmd_cin[i];
          m_ctrl[i] = cmd_ctrl[i];
          m_pend[i] = alu_fn(m_a[i], m_b[i], m_cin[i], m_ctrl[i]);
          m_age[i]  = 0;
          m_phase[i] = 1;
        end
      end else if (m_phase[i] == 1) begin
        m_age[i]++;
        if (m_age[i] == settle_of(i)) begin
          {m_cout[i], m_res[i]} = m_pend[i];
          m_acc[i]   = m_res[i];
          m_phase[i] = 2;
        end
      end else begin
        if (rsp_ready[i]) begin
          m_cnt[i]   = m_cnt[i] + 16'd1;
          m_phase[i] = 0;
          $display("txn inst%0d op_count=%0d a=0x%04h b=0x%04h ctrl=%0d result=0x%04h cout=%0d",
                   i, m_cnt[i], m_a[i], m_b[i], m_ctrl[i], m_res[i], m_cout[i]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("cmd_ready",  i, 32'(cmd_ready[i]),  32'(m_phase[i] == 0));
      chk("rsp_valid",  i, 32'(rsp_valid[i]),  32'(m_phase[i] == 2));
      chk("busy",       i, 32'(busy[i]),       32'(m_phase[i] != 0));
      chk("alu_a",      i, 32'(alu_a[i]),      32'(m_a[i]));
      chk("alu_b",      i, 32'(alu_b[i]),      32'(m_b[i]));
      chk("alu_cin",    i, 32'(alu_cin[i]),    32'(m_cin[i]));
      chk("alu_ctrl",   i, 32'(alu_ctrl[i]),   32'(m_ctrl[i]));
      chk("rsp_result", i, 32'(rsp_result[i]), 32'(m_res[i]));
      chk("rsp_cout",   i, 32'(rsp_cout[i]),   32'(m_cout[i]));
      chk("op_count",   i, 32'(op_count[i]),   32'(m_cnt[i]));
    end
  end

  // Accept-edge monitor, sampled before the edge updates the DUT
  int n_acc[2] = '{0, 0};
  int acc1_edges[$];
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst_n && cmd_valid[i] && cmd_ready[i]) begin
        n_acc[i]++;
        if (i == 1) acc1_edges.push_back(cyc + 1);
      end
    end
  end

  task automatic drive_cmd(int i, logic [15:0] a, logic [15:0] b, logic cin, logic [2:0] ctrl, logic chain);
    cmd_valid[i] = 1'b1; cmd_a[i] = a; cmd_b[i] = b;
    cmd_cin[i] = cin; cmd_ctrl[i] = ctrl; cmd_chain[i] = chain;
  endtask

  task automatic issue(int i, logic [15:0] a, logic [15:0] b, logic cin, logic [2:0] ctrl,
                       logic chain, output int e0);
    int n;
    n = 0;
    @(negedge clk);
    drive_cmd(i, a, b, cin, ctrl, chain);
    while (!cmd_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", i, 32'(n < 100), 32'd1);
    e0 = cyc + 1;
    @(negedge clk);
    cmd_valid[i] = 1'b0;
    cmd_a[i] = 16'($urandom); cmd_b[i] = 16'($urandom);
    cmd_cin[i] = 1'($urandom); cmd_ctrl[i] = 3'($urandom); cmd_chain[i] = 1'($urandom);
  endtask

  task automatic wait_rsp(int i, output int vc);
    int n;
    n = 0;
    while (!rsp_valid[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", i, 32'(n < 100), 32'd1);
    vc = cyc;
  endtask

  task automatic handshake(int i);
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, vc, na;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_a[i] = '0; cmd_b[i] = '0; cmd_cin[i] = 1'b0;
      cmd_ctrl[i] = '0; cmd_chain[i] = 1'b0; rsp_ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 0, 32'(cmd_ready[0]), 32'd1);
    chk("reset_op_count", 1, 32'(op_count[1]), 32'd0);
    chk("reset_alu_a", 1, 32'(alu_a[1]), 32'd0);
    #1 rst_n = 1'b1;

    // Basic add and chaining on the SETTLE=1 instance
    issue(0, 16'h0002, 16'h0001, 1'b1, 3'b000, 1'b0, e0);
    chk("basic_alu_a", 0, 32'(alu_a[0]), 32'h0002);
    chk("basic_alu_cin", 0, 32'(alu_cin[0]), 32'd1);
    wait_rsp(0, vc);
    chk("latency_s1", 0, 32'(vc - e0), 32'd1);
    chk("basic_result", 0, 32'(rsp_result[0]), 32'h0004);
    chk("basic_cout", 0, 32'(rsp_cout[0]), 32'd0);
    handshake(0);
    chk("basic_op_count", 0, 32'(op_count[0]), 32'd1);

    issue(0, 16'hFFFF, 16'h0001, 1'b0, 3'b000, 1'b1, e0);
    chk("chain_alu_a", 0, 32'(alu_a[0]), 32'h0004);
    wait_rsp(0, vc);
    chk("chain1_result", 0, 32'(rsp_result[0]), 32'h0005);
    handshake(0);
    issue(0, 16'h1234, 16'hFFFB, 1'b0, 3'b000, 1'b1, e0);
    wait_rsp(0, vc);
    chk("chain2_result", 0, 32'(rsp_result[0]), 32'h0000);
    chk("chain2_cout", 0, 32'(rsp_cout[0]), 32'd1);
    handshake(0);

    // Backpressure with a competing command held valid
    issue(0, 16'h00FF, 16'h0F0F, 1'b0, 3'b111, 1'b0, e0);
    wait_rsp(0, vc);
    na = n_acc[0];
    drive_cmd(0, 16'h1111, 16'h2222, 1'b0, 3'b000, 1'b0);
    repeat (6) begin
      @(negedge clk);
      chk("bp_cmd_ready", 0, 32'(cmd_ready[0]), 32'd0);
      chk("bp_result_held", 0, 32'(rsp_result[0]), 32'h000F);
    end
    chk("bp_no_accept", 0, 32'(n_acc[0] - na), 32'd0);
    handshake(0);
    chk("bp_ready_after", 0, 32'(cmd_ready[0]), 32'd1);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    chk("bp_second_accept", 0, 32'(n_acc[0] - na), 32'd1);
    wait_rsp(0, vc);
    chk("bp_second_result", 0, 32'(rsp_result[0]), 32'h3333);
    handshake(0);
    chk("bp_op_count", 0, 32'(op_count[0]), 32'd5);

    // Settle latency and back-to-back spacing on the SETTLE=3 instance
    issue(1, 16'h0100, 16'h0023, 1'b1, 3'b000, 1'b0, e0);
    wait_rsp(1, vc);
    chk("latency_s3", 1, 32'(vc - e0), 32'd3);
    chk("s3_result", 1, 32'(rsp_result[1]), 32'h0124);
    handshake(1);

    acc1_edges.delete();
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    drive_cmd(1, 16'h0003, 16'h0005, 1'b0, 3'b001, 1'b0);
    repeat (16) @(negedge clk);
    cmd_valid[1] = 1'b0;
    repeat (6) @(negedge clk);
    rsp_ready[1] = 1'b0;
    chk("b2b_count", 1, 32'(acc1_edges.size() >= 3), 32'd1);
    for (int k = 1; k < acc1_edges.size(); k++)
      chk("b2b_spacing", 1, 32'(acc1_edges[k] - acc1_edges[k-1]), 32'd5);

    // Reset during ISSUE, then during RESP
    issue(1, 16'h0AAA, 16'h0555, 1'b0, 3'b000, 1'b0, e0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_issue_alu_a", 1, 32'(alu_a[1]), 32'd0);
    chk("rst_issue_busy", 1, 32'(busy[1]), 32'd0);
    chk("rst_issue_op_count", 1, 32'(op_count[1]), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    issue(1, 16'h0010, 16'h0020, 1'b0, 3'b000, 1'b0, e0);
    wait_rsp(1, vc);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 1, 32'(rsp_valid[1]), 32'd0);
    chk("rst_resp_result", 1, 32'(rsp_result[1]), 32'd0);
    chk("rst_resp_op_count", 1, 32'(op_count[1]), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    issue(1, 16'hBEEF, 16'h0007, 1'b0, 3'b000, 1'b1, e0);
    wait_rsp(1, vc);
    chk("post_rst_chain_result", 1, 32'(rsp_result[1]), 32'h0007);
    handshake(1);
    chk("post_rst_op_count", 1, 32'(op_count[1]), 32'd1);

    // Randomized traffic on both instances with one reset pulse
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1502) rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
        cmd_valid[i] = ($urandom_range(0, 9) < 6);
        cmd_a[i]     = 16'($urandom);
        cmd_b[i]     = 16'($urandom);
        cmd_cin[i]   = 1'($urandom);
        cmd_ctrl[i]  = pick_ctrl();
        cmd_chain[i] = ($urandom_range(0, 2) == 0);
        rsp_ready[i] = 1'($urandom);
      end
      if (c == 1500) #2 rst_n = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      rsp_ready[i] = 1'b1;
    end
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
